// File: rtl/corner_filter.sv
// -----------------------------------------------------------------------------
// corner_filter
//
// Temporal smoothing and plausibility filter for the four corners of a
// detected quadrilateral. Once per video frame (falling edge of VGA_VS) the
// raw corners are captured and checked for a sane shape. While tracking is
// locked, each corner must also stay close to the previous filtered value.
// Accepted frames update the filtered corners one coordinate per cycle with a
// first-order IIR. Every frame, accepted or rejected, produces one result
// that is held until the consumer takes it.
//
// Parameters
//   SHIFT        IIR weight 2^-SHIFT (0..4)
//   LOCK_FRAMES  good frames needed to lock / bad frames needed to unlock
//   MAX_JUMP     largest per-coordinate deviation accepted while locked
//   MIN_SIZE     minimum quad width and height in pixels
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   VGA_VS                  vertical sync; a falling edge ends a frame
//   *_prev_x / *_prev_y     raw corners (10 bit each)
//   out_ready               consumer accepts the result
//   filt_*                  smoothed corners (10 bit each)
//   out_valid               result available, held until accepted
//   frame_good              last checked frame was accepted
//   locked                  tracking locked
//   dropped_frames          frame ends seen while busy (saturates at 255)
// -----------------------------------------------------------------------------
module corner_filter #(
    parameter int         SHIFT       = 2,
    parameter int         LOCK_FRAMES = 4,
    parameter logic [9:0] MAX_JUMP    = 10'd64,
    parameter logic [9:0] MIN_SIZE    = 10'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       VGA_VS,
    input  logic [9:0] top_left_prev_x,
    input  logic [9:0] top_left_prev_y,
    input  logic [9:0] top_right_prev_x,
    input  logic [9:0] top_right_prev_y,
    input  logic [9:0] bot_left_prev_x,
    input  logic [9:0] bot_left_prev_y,
    input  logic [9:0] bot_right_prev_x,
    input  logic [9:0] bot_right_prev_y,
    input  logic       out_ready,
    output logic [9:0] filt_tl_x,
    output logic [9:0] filt_tl_y,
    output logic [9:0] filt_tr_x,
    output logic [9:0] filt_tr_y,
    output logic [9:0] filt_bl_x,
    output logic [9:0] filt_bl_y,
    output logic [9:0] filt_br_x,
    output logic [9:0] filt_br_y,
    output logic       out_valid,
    output logic       frame_good,
    output logic       locked,
    output logic [7:0] dropped_frames
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        CHECK   = 3'd2,
        FILTER  = 3'd3,
        PRESENT = 3'd4
    } state_t;

    localparam int              CW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0]   LOCK_MAX = CW'(LOCK_FRAMES);
    localparam logic signed [11:0] X_LIM = 12'sd639;
    localparam logic signed [11:0] Y_LIM = 12'sd479;

    // Coordinate order used by every array below:
    // 0 tl_x, 1 tl_y, 2 tr_x, 3 tr_y, 4 bl_x, 5 bl_y, 6 br_x, 7 br_y.
    // Even indices are x, odd indices are y.
    function automatic logic [9:0] filt_reset_val(input int idx);
        case (idx)
            2, 6:    filt_reset_val = 10'd639;
            5, 7:    filt_reset_val = 10'd479;
            default: filt_reset_val = 10'd0;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic          vs_q;
    logic          vs_edge;
    logic [9:0]    raw_in [8];
    logic [9:0]    raw_q  [8];
    logic [9:0]    raw_d  [8];
    logic [9:0]    filt_q [8];
    logic [9:0]    filt_d [8];
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] good_cnt_q, good_cnt_d;
    logic [CW-1:0] miss_cnt_q, miss_cnt_d;
    logic [CW-1:0] good_inc, miss_inc;
    logic          locked_q, locked_d;
    logic          frame_good_q, frame_good_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    dropped_q, dropped_d;

    logic [7:0]    jump_ok;
    logic          geom_ok;
    logic          frame_ok;

    logic signed [10:0] step_diff;
    logic signed [10:0] step_shift;
    logic signed [11:0] step_sum;
    logic signed [11:0] step_lim;
    logic [9:0]         step_res;

    assign raw_in[0] = top_left_prev_x;
    assign raw_in[1] = top_left_prev_y;
    assign raw_in[2] = top_right_prev_x;
    assign raw_in[3] = top_right_prev_y;
    assign raw_in[4] = bot_left_prev_x;
    assign raw_in[5] = bot_left_prev_y;
    assign raw_in[6] = bot_right_prev_x;
    assign raw_in[7] = bot_right_prev_y;

    // Previous VS is 1 and the live input is 0.
    assign vs_edge = vs_q & ~VGA_VS;

    // Per-coordinate deviation check against the current filtered value,
    // done on an 11-bit unsigned magnitude so no wrap can hide a big jump.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_jump
            logic [10:0] abs_diff;
            assign abs_diff = (raw_q[gi] >= filt_q[gi])
                            ? ({1'b0, raw_q[gi]}  - {1'b0, filt_q[gi]})
                            : ({1'b0, filt_q[gi]} - {1'b0, raw_q[gi]});
            assign jump_ok[gi] = (abs_diff <= {1'b0, MAX_JUMP});
        end
    endgenerate

    // Shape check. The size subtractions only matter once the ordering
    // terms hold, so a wrapped difference never slips through.
    assign geom_ok = (raw_q[0] < raw_q[2]) &&
                     (raw_q[4] < raw_q[6]) &&
                     (raw_q[1] < raw_q[5]) &&
                     (raw_q[3] < raw_q[7]) &&
                     ((raw_q[2] - raw_q[0]) >= MIN_SIZE) &&
                     ((raw_q[5] - raw_q[1]) >= MIN_SIZE);

    assign frame_ok = geom_ok && (!locked_q || (&jump_ok));

    assign good_inc = (good_cnt_q >= LOCK_MAX) ? LOCK_MAX : good_cnt_q + CW'(1);
    assign miss_inc = (miss_cnt_q >= LOCK_MAX) ? LOCK_MAX : miss_cnt_q + CW'(1);

    // One IIR step for the coordinate selected by idx_q. The arithmetic
    // shift of a negative difference rounds toward negative infinity.
    always_comb begin
        step_diff  = $signed({1'b0, raw_q[idx_q]}) - $signed({1'b0, filt_q[idx_q]});
        step_shift = step_diff >>> SHIFT;
        if (locked_q) begin
            step_sum = $signed({2'b00, filt_q[idx_q]}) + $signed({step_shift[10], step_shift});
        end else begin
            step_sum = $signed({2'b00, raw_q[idx_q]});
        end
        step_lim = idx_q[0] ? Y_LIM : X_LIM;
        if (step_sum < 12'sd0) begin
            step_res = 10'd0;
        end else if (step_sum > step_lim) begin
            step_res = step_lim[9:0];
        end else begin
            step_res = step_sum[9:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        raw_d        = raw_q;
        filt_d       = filt_q;
        idx_d        = idx_q;
        good_cnt_d   = good_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        locked_d     = locked_q;
        frame_good_d = frame_good_q;
        out_valid_d  = out_valid_q;
        dropped_d    = dropped_q;

        // A frame end that arrives while busy is counted and ignored.
        if (vs_edge && (state_q != IDLE) && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (vs_edge) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                raw_d   = raw_in;
                state_d = CHECK;
            end
            CHECK: begin
                if (frame_ok) begin
                    frame_good_d = 1'b1;
                    miss_cnt_d   = '0;
                    good_cnt_d   = good_inc;
                    if (good_inc >= LOCK_MAX) begin
                        locked_d = 1'b1;
                    end
                    idx_d   = 3'd0;
                    state_d = FILTER;
                end else begin
                    frame_good_d = 1'b0;
                    miss_cnt_d   = miss_inc;
                    if (locked_q && (miss_inc >= LOCK_MAX)) begin
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                        miss_cnt_d = '0;
                    end
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            FILTER: begin
                filt_d[idx_q] = step_res;
                idx_d         = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    out_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vs_q         <= 1'b0;
            idx_q        <= 3'd0;
            good_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            frame_good_q <= 1'b0;
            out_valid_q  <= 1'b0;
            dropped_q    <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                raw_q[i]  <= 10'd0;
                filt_q[i] <= filt_reset_val(i);
            end
        end else begin
            state_q      <= state_d;
            vs_q         <= VGA_VS;
            idx_q        <= idx_d;
            good_cnt_q   <= good_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            frame_good_q <= frame_good_d;
            out_valid_q  <= out_valid_d;
            dropped_q    <= dropped_d;
            for (int i = 0; i < 8; i++) begin
                raw_q[i]  <= raw_d[i];
                filt_q[i] <= filt_d[i];
            end
        end
    end

    assign filt_tl_x      = filt_q[0];
    assign filt_tl_y      = filt_q[1];
    assign filt_tr_x      = filt_q[2];
    assign filt_tr_y      = filt_q[3];
    assign filt_bl_x      = filt_q[4];
    assign filt_bl_y      = filt_q[5];
    assign filt_br_x      = filt_q[6];
    assign filt_br_y      = filt_q[7];
    assign out_valid      = out_valid_q;
    assign frame_good     = frame_good_q;
    assign locked         = locked_q;
    assign dropped_frames = dropped_q;

endmodule
